// File: rtl/trap_entry_seq.sv
// rtl/trap_entry_seq.sv - trap entry / trap return sequencer for M and S privilege levels
module trap_entry_seq #(
    parameter bit VEC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_req,
    input  logic        int_target_m,
    input  logic        int_target_s,
    input  logic [63:0] int_cause,
    input  logic [3:0]  priv,
    input  logic [63:0] pc_now,
    input  logic        pipe_idle,
    input  logic        mret,
    input  logic        sret,
    input  logic [63:0] mtvec,
    input  logic [63:0] stvec,
    input  logic [63:0] mepc_in,
    input  logic [63:0] sepc_in,
    input  logic        mie,
    input  logic        mpie,
    input  logic        sie,
    input  logic        spie,
    input  logic        spp,
    input  logic [1:0]  mpp,
    output logic        hold_pipe,
    output logic        epc_we_m,
    output logic        epc_we_s,
    output logic        cause_we_m,
    output logic        cause_we_s,
    output logic [63:0] epc_d,
    output logic [63:0] cause_d,
    output logic        status_we,
    output logic        mie_d,
    output logic        mpie_d,
    output logic        sie_d,
    output logic        spie_d,
    output logic        spp_d,
    output logic [1:0]  mpp_d,
    output logic        priv_we,
    output logic [3:0]  priv_d,
    output logic        pc_redirect,
    output logic [63:0] pc_new,
    output logic        int_ack
);

    localparam logic [3:0] PRIV_M = 4'b1000;
    localparam logic [3:0] PRIV_S = 4'b0010;
    localparam logic [3:0] PRIV_U = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SAVE,
        UPDATE,
        REDIRECT,
        RET
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [63:0] cause_q;
    logic [63:0] epc_q;
    logic        tgt_m_q;
    logic        ret_m_q;

    logic [63:0] tvec;
    logic [63:0] tvec_base;
    logic [63:0] vec_off;
    logic        vec_hit;
    logic [1:0]  mpp_from_priv;
    logic [3:0]  mret_priv;
    logic        unused_inputs;

    // int_target_s is implied by !int_target_m; priv[2] and priv[0] never steer anything
    assign unused_inputs = ^{int_target_s, priv[2], priv[0]};

    assign tvec      = tgt_m_q ? mtvec : stvec;
    assign tvec_base = {tvec[63:2], 2'b00};
    assign vec_hit   = VEC_EN && (tvec[1:0] == 2'b01) && cause_q[63];
    assign vec_off   = vec_hit ? {56'd0, cause_q[5:0], 2'b00} : 64'd0;

    assign mpp_from_priv = priv[3] ? 2'b11 : (priv[1] ? 2'b01 : 2'b00);
    assign mret_priv     = (mpp == 2'b11) ? PRIV_M : ((mpp == 2'b01) ? PRIV_S : PRIV_U);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cause_q <= 64'd0;
            epc_q   <= 64'd0;
            tgt_m_q <= 1'b0;
            ret_m_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (int_req) begin
                    cause_q <= int_cause;
                    tgt_m_q <= int_target_m;
                end else if ((mret || sret) && pipe_idle) begin
                    ret_m_q <= mret;
                end
            end
            if (state_q == DRAIN && pipe_idle) begin
                epc_q <= pc_now;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_pipe   = 1'b0;
        epc_we_m    = 1'b0;
        epc_we_s    = 1'b0;
        cause_we_m  = 1'b0;
        cause_we_s  = 1'b0;
        epc_d       = 64'd0;
        cause_d     = 64'd0;
        status_we   = 1'b0;
        mie_d       = 1'b0;
        mpie_d      = 1'b0;
        sie_d       = 1'b0;
        spie_d      = 1'b0;
        spp_d       = 1'b0;
        mpp_d       = 2'b00;
        priv_we     = 1'b0;
        priv_d      = 4'b0000;
        pc_redirect = 1'b0;
        pc_new      = 64'd0;
        int_ack     = 1'b0;

        case (state_q)
            IDLE: begin
                // an interrupt in the same cycle as a return drops the return
                if (int_req) begin
                    state_d = DRAIN;
                end else if ((mret || sret) && pipe_idle) begin
                    state_d = RET;
                end
            end
            DRAIN: begin
                hold_pipe = 1'b1;
                if (pipe_idle) begin
                    state_d = SAVE;
                end
            end
            SAVE: begin
                hold_pipe  = 1'b1;
                epc_d      = epc_q;
                cause_d    = cause_q;
                epc_we_m   = tgt_m_q;
                cause_we_m = tgt_m_q;
                epc_we_s   = !tgt_m_q;
                cause_we_s = !tgt_m_q;
                state_d    = UPDATE;
            end
            UPDATE: begin
                hold_pipe = 1'b1;
                status_we = 1'b1;
                priv_we   = 1'b1;
                mie_d     = mie;
                mpie_d    = mpie;
                sie_d     = sie;
                spie_d    = spie;
                spp_d     = spp;
                mpp_d     = mpp;
                if (tgt_m_q) begin
                    mpie_d = mie;
                    mie_d  = 1'b0;
                    mpp_d  = mpp_from_priv;
                    priv_d = PRIV_M;
                end else begin
                    spie_d = sie;
                    sie_d  = 1'b0;
                    spp_d  = priv[1];
                    priv_d = PRIV_S;
                end
                state_d = REDIRECT;
            end
            REDIRECT: begin
                hold_pipe   = 1'b1;
                pc_redirect = 1'b1;
                int_ack     = 1'b1;
                pc_new      = tvec_base + vec_off;
                state_d     = IDLE;
            end
            RET: begin
                hold_pipe   = 1'b1;
                status_we   = 1'b1;
                priv_we     = 1'b1;
                pc_redirect = 1'b1;
                mie_d       = mie;
                mpie_d      = mpie;
                sie_d       = sie;
                spie_d      = spie;
                spp_d       = spp;
                mpp_d       = mpp;
                if (ret_m_q) begin
                    mie_d  = mpie;
                    mpie_d = 1'b1;
                    mpp_d  = 2'b00;
                    priv_d = mret_priv;
                    pc_new = mepc_in;
                end else begin
                    sie_d  = spie;
                    spie_d = 1'b1;
                    spp_d  = 1'b0;
                    priv_d = spp ? PRIV_S : PRIV_U;
                    pc_new = sepc_in;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/trap_entry_seq.md
TRAP_ENTRY_SEQ -- requirements
Module: trap_entry_seq

Interface
REQ-001 Parameter VEC_EN, default 1: 1 enables vectored interrupt mode (tvec[1:0]==2'b01); 0 makes every trap direct.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 int_req / int_target_m / int_target_s  in  1 each  interrupt request and target from the interrupt controller.
REQ-005 int_cause  in  64  cause; bit63=1 for interrupts, low bits = code.
REQ-006 priv  in  4  current privilege, one-hot: [3]=M, [1]=S, [0]=U, [2] unused.
REQ-007 pc_now  in  64  PC of the oldest unexecuted instruction.
REQ-008 pipe_idle  in  1  pipeline drained and stalled.
REQ-009 mret / sret  in  1 each  return request; valid only while pipe_idle=1.
REQ-010 mtvec / stvec / mepc_in / sepc_in  in  64 each  current CSR values.
REQ-011 mie, mpie, sie, spie, spp  in  1 each; mpp  in  2  current status fields.
REQ-012 hold_pipe  out  1  asks the pipeline to stop issuing.
REQ-013 epc_we_m / epc_we_s / cause_we_m / cause_we_s  out  1 each; epc_d / cause_d  out  64  CSR write ports.
REQ-014 status_we  out  1; mie_d, mpie_d, sie_d, spie_d, spp_d  out  1 each; mpp_d  out  2  status write port.
REQ-015 priv_we  out  1; priv_d  out  4  privilege update, same one-hot encoding as priv.
REQ-016 pc_redirect  out  1; pc_new  out  64  fetch redirect.
REQ-017 int_ack  out  1  one-cycle pulse marking trap entry complete.

Function
REQ-018 FSM states: IDLE, DRAIN, SAVE, UPDATE, REDIRECT, RET.
REQ-019 IDLE, int_req=1: latch int_cause and target, then go to DRAIN. Target is M if int_target_m=1, otherwise S.
REQ-020 IDLE, int_req=0, (mret|sret)&pipe_idle: latch return type, then go to RET. mret wins over sret.
REQ-021 int_req and mret/sret in the same cycle: the interrupt wins; the return is dropped and must be re-presented by the pipeline.
REQ-022 hold_pipe=1 in every state except IDLE.
REQ-023 DRAIN: stay until pipe_idle=1; on that cycle latch pc_now as epc and go to SAVE. No timeout.
REQ-024 Once the request is latched, the trap is committed; deassertion of int_req or changes to int_cause after leaving IDLE are ignored.
REQ-025 SAVE, one cycle: epc_d=latched epc; cause_d=latched cause; pulse epc_we_x and cause_we_x for the target only.
REQ-026 UPDATE (M target), one cycle: status_we=1, mpie_d=mie, mie_d=0, mpp_d=11/01/00 for priv M/S/U; priv_d=4'b1000; priv_we=1.
REQ-027 UPDATE (S target), one cycle: spie_d=sie, sie_d=0, spp_d=priv[1]; priv_d=4'b0010; priv_we=1.
REQ-028 During status_we, fields not named in REQ-026..REQ-032 are driven with their current input values.
REQ-029 REDIRECT, one cycle: pc_redirect=1 and int_ack=1, then return to IDLE.
- tvec = mtvec for an M target, stvec for an S target; base = {tvec[63:2],2'b00}.
- pc_new = base + (cause[5:0]<<2) when VEC_EN=1, tvec[1:0]==01 and cause[63]=1; otherwise pc_new = base.
- 64-bit add; carry out is discarded.
REQ-030 RET (mret), one cycle: status_we=1, mie_d=mpie, mpie_d=1, mpp_d=00; priv_d = decode(mpp), where 11->M, 01->S, 00->U and 10->U; priv_we=1; pc_redirect=1, pc_new=mepc_in. Then return to IDLE.
REQ-031 RET (sret), one cycle: sie_d=spie, spie_d=1, spp_d=0; priv_d = spp ? S : U; priv_we=1; pc_redirect=1, pc_new=sepc_in. Then return to IDLE.
REQ-032 In RET, no epc or cause write enables assert; int_ack stays 0.
REQ-033 Latency, int_req sampled at edge N with pipe_idle=1: DRAIN after N, SAVE after N+1, UPDATE after N+2, REDIRECT after N+3. Minimum 4 cycles, request to redirect.
REQ-034 All write enables, pc_redirect and int_ack are single-cycle pulses; they are never asserted in IDLE or DRAIN.
REQ-035 A new int_req is accepted only in IDLE; back-to-back traps need at least one IDLE cycle between them.

Reset
REQ-036 rst=1 forces state IDLE immediately and asynchronously, mid-sequence included.
REQ-037 During reset, all outputs are 0, including hold_pipe, priv_d, pc_new and every *_d bus.
REQ-038 During reset, all latched registers (cause, target, epc, return type) are 0.
REQ-039 A sequence interrupted by reset leaves no partial pulse after reset release.

Verification
REQ-040 Scenario M interrupt.
- Stimulus: priv=U, int_req=1, int_target_m=1, cause=0x8000_0000_0000_0007, mtvec=0x1001, pipe_idle=1, pc_now=0x2000.
- Response: epc_we_m with epc_d=0x2000; mpp_d=00, mie_d=0, mpie_d=old mie; pc_new=0x101C with int_ack, 4 cycles after request.
REQ-041 Scenario S interrupt, direct mode.
- Stimulus: priv=S, target S, cause code 9, stvec=0x3000.
- Response: epc_we_s/cause_we_s only; spp_d=1; priv_d=0010; pc_new=0x3000.
REQ-042 Scenario drain wait.
- Stimulus: pipe_idle held 0 for 5 cycles while int_req drops to 0.
- Response: hold_pipe high throughout; trap still completes; pc_now latched on the cycle pipe_idle rises.
REQ-043 Scenario collision.
- Stimulus: int_req and mret in the same IDLE cycle.
- Response: trap entry sequence only; no RET redirect to mepc.
REQ-044 Scenario return.
- Stimulus: mret with mpp=01, mpie=1, mepc_in=0x4000.
- Response: priv_d=0010, mie_d=1, mpie_d=1, mpp_d=00, pc_new=0x4000, all in one cycle.
REQ-045 Scenario reset mid-sequence.
- Stimulus: rst asserted in UPDATE.
- Response: outputs go 0 without waiting for a clock edge; after release the block is in IDLE and no pulses occur.
